// File: rtl/estagio_busca.sv
// Instruction-fetch stage: fetch PC, next-PC selection, word-addressed instruction
// memory with a loader write port, and the IF/ID register handed to decode.
module estagio_busca #(
  parameter int               WIDTH     = 32,
  parameter int               MEM_DEPTH = 64,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             mem_we,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] if_id_pc,
  output logic [WIDTH-1:0] if_id_pc4,
  output logic [WIDTH-1:0] if_id_instr,
  output logic             if_id_valid,
  output logic             misaligned
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] if_id_pc_q, if_id_pc_d;
  logic [WIDTH-1:0] if_id_pc4_q, if_id_pc4_d;
  logic [WIDTH-1:0] if_id_instr_q, if_id_instr_d;
  logic             if_id_valid_q, if_id_valid_d;
  logic             misaligned_q, misaligned_d;

  logic [WIDTH-1:0] pc_plus4;
  logic             fetch_in_range;
  logic [WIDTH-1:0] fetch_instr;

  // Address bits outside the word index are deliberately ignored by the write port.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[WIDTH-1:AW+2], mem_addr[1:0]};

  // Reads above the memory return a NOP instead of aliasing onto low words.
  always_comb begin
    pc_plus4       = pc_q + WIDTH'(4);
    fetch_in_range = (pc_q[WIDTH-1:AW+2] == '0);
    fetch_instr    = fetch_in_range ? mem_q[pc_q[AW+1:2]] : '0;
  end

  // A redirect overrides a stall so a taken branch is never lost.
  always_comb begin
    pc_d         = pc_plus4;
    misaligned_d = branch_taken & (|branch_target[1:0]);
    if (branch_taken) begin
      pc_d = {branch_target[WIDTH-1:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    if_id_pc_d    = pc_q;
    if_id_pc4_d   = pc_plus4;
    if_id_instr_d = fetch_instr;
    if_id_valid_d = 1'b1;
    if (flush || branch_taken) begin
      if_id_pc_d    = '0;
      if_id_pc4_d   = '0;
      if_id_instr_d = '0;
      if_id_valid_d = 1'b0;
    end else if (stall) begin
      if_id_pc_d    = if_id_pc_q;
      if_id_pc4_d   = if_id_pc4_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= '0;
      if_id_instr_q <= '0;
      if_id_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // The loader keeps writing through reset so a program can be preloaded.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_addr[AW+1:2]] <= mem_wdata;
    end
  end

  assign pc          = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_estagio_busca.sv
// Scoreboard bench for estagio_busca: a behavioural fetch model predicts every
// post-edge state, a separate monitor pops predictions and compares them.
module tb_estagio_busca;

  localparam int          MEM_DEPTH = 64;
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_DEPTH);

  logic        clock = 1'b0;
  logic        reset, stall, flush, branch_taken, mem_we;
  logic [31:0] branch_target, mem_addr, mem_wdata;
  logic [31:0] pc, if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid, misaligned;

  estagio_busca #(.WIDTH(32), .MEM_DEPTH(MEM_DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pc(pc), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] idPc;
    logic [31:0] idPc4;
    logic [31:0] idInstr;
    logic        idValid;
    logic        mis;
  } expT;

  expT         expQ[$];
  int          total = 0;
  int          bad = 0;

  logic [31:0] mMem [MEM_DEPTH];
  logic [31:0] mPc = 32'h0;
  expT         mIfId;

  function automatic logic [31:0] mFetch(input logic [31:0] a);
    if (a < MEM_BYTES) return mMem[a / 4];
    return 32'h0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Drives one cycle of inputs and pushes the state expected after the next edge.
  task automatic applyStimulus(input logic rst, input logic stl, input logic fl,
                               input logic br, input logic [31:0] tgt,
                               input logic we, input logic [31:0] waddr,
                               input logic [31:0] wdata);
    expT e;
    logic [31:0] fetched;
    @(negedge clock);
    reset = rst; stall = stl; flush = fl; branch_taken = br;
    branch_target = tgt; mem_we = we; mem_addr = waddr; mem_wdata = wdata;
    e = mIfId;
    e.mis = 1'b0;
    if (rst) begin
      mPc = 32'h0;
      e.idPc = 0; e.idPc4 = 0; e.idInstr = 0; e.idValid = 1'b0;
    end else begin
      fetched = mFetch(mPc);
      e.mis = br && (tgt % 4 != 0);
      if (fl || br) begin
        e.idPc = 0; e.idPc4 = 0; e.idInstr = 0; e.idValid = 1'b0;
      end else if (!stl) begin
        e.idPc = mPc; e.idPc4 = mPc + 32'd4; e.idInstr = fetched; e.idValid = 1'b1;
      end
      if (br) mPc = tgt - (tgt % 4);
      else if (!stl) mPc = mPc + 32'd4;
    end
    if (we) mMem[(waddr / 4) % MEM_DEPTH] = wdata;
    e.pc = mPc;
    mIfId = e;
    expQ.push_back(e);
  endtask

  task automatic idle(input logic stl, input logic fl, input logic br, input logic [31:0] tgt);
    applyStimulus(1'b0, stl, fl, br, tgt, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    expT e;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pc", pc, e.pc);
        checkOutput("if_id_pc", if_id_pc, e.idPc);
        checkOutput("if_id_pc4", if_id_pc4, e.idPc4);
        checkOutput("if_id_instr", if_id_instr, e.idInstr);
        checkOutput("if_id_valid", 32'(if_id_valid), 32'(e.idValid));
        checkOutput("misaligned", 32'(misaligned), 32'(e.mis));
      end
    end
  end

  initial begin
    int r;
    logic [31:0] tgt;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    mIfId = '{32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    for (int i = 0; i < MEM_DEPTH; i++) mMem[i] = 32'h0;

    // Preload the whole memory under reset; words 0..3 hold the directed program.
    for (int i = 0; i < MEM_DEPTH; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 4),
                    (i < 4) ? 32'(8'h11 * (i + 1)) : $urandom);

    idle(0, 0, 0, 0);
    idle(0, 0, 0, 0);
    idle(1, 0, 0, 0);
    idle(1, 0, 0, 0);
    idle(0, 0, 0, 0);
    idle(0, 0, 1, 32'h0000000E);
    idle(0, 0, 0, 0);
    idle(0, 0, 1, 32'h00000100);
    idle(0, 0, 0, 0);
    idle(0, 0, 1, 32'hFFFFFFFC);
    idle(0, 0, 0, 0);
    idle(0, 0, 0, 0);
    idle(1, 1, 0, 0);
    idle(1, 0, 1, 32'h00000008);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, mPc, 32'hCAFEF00D);
    idle(0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    idle(0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) tgt = $urandom_range(0, 270);
      else if (r < 8) tgt = 32'hFFFFFFF0 + $urandom_range(0, 15);
      else tgt = $urandom;
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, tgt,
                    $urandom_range(0, 3) == 0,
                    ($urandom_range(0, 3) == 0) ? mPc : $urandom, $urandom);
    end
    idle(0, 0, 0, 0);

    for (int w = 0; w < 5 && expQ.size() > 0; w++) @(posedge clock);
    #2;
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/estagio_busca.md
Name: estagio_busca

Overview:
Instruction-fetch stage fed by the PC/PC+4 datapath. It owns the fetch PC register, the next-PC selection (sequential PC+4 or branch redirect) and a word-addressed instruction memory. It also owns the IF/ID pipeline register that hands {pc, pc+4, instruction, valid} to decode. Stall and flush inputs from the hazard logic, plus a bench/loader write port for the instruction memory.

Parameters:
WIDTH, 32, datapath/address/instruction width in bits
MEM_DEPTH, 64, instruction memory depth in words (power of two)
RESET_PC, 32'h00000000, PC value loaded on reset

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC and IF/ID contents
flush  input  1  replace IF/ID contents with a bubble
branch_taken  input  1  redirect fetch to branch_target
branch_target  input  WIDTH  redirect byte address
mem_we  input  1  instruction memory write enable
mem_addr  input  WIDTH  byte address for memory write; word index = mem_addr[log2(MEM_DEPTH)+1:2]
mem_wdata  input  WIDTH  instruction word to write
pc  output  WIDTH  current fetch PC (registered)
if_id_pc  output  WIDTH  PC of instruction held in IF/ID
if_id_pc4  output  WIDTH  if_id_pc + 4
if_id_instr  output  WIDTH  fetched instruction word
if_id_valid  output  1  IF/ID holds a real instruction
misaligned  output  1  one-cycle pulse: accepted branch_target had bits[1:0] != 0

Behaviour:
- Clocking: single clock; reset is synchronous and active-high; everything updates on rising clock edge.
- Reset: pc=RESET_PC; if_id_pc=0, if_id_pc4=0, if_id_instr=0, if_id_valid=0, misaligned=0. Memory contents are not cleared. mem_we writes are honoured during reset.
- Memory read: combinational on current pc. Word index = pc[log2(MEM_DEPTH)+1:2]. If pc >= 4*MEM_DEPTH, read data = 32'h00000000 (NOP); no aliasing.
- Memory write: synchronous on rising edge when mem_we=1. A fetch of the same word in that cycle sees the old value; the new value is visible from the next cycle.
- PC update priority, highest first: reset > branch_taken > stall > sequential.
  - branch_taken=1: pc <= {branch_target[WIDTH-1:2], 2'b00}. misaligned <= |branch_target[1:0]. Applies even when stall=1.
  - stall=1, no branch: pc holds.
  - Otherwise: pc <= pc + 4, modulo 2^WIDTH (0xFFFFFFFC wraps to 0x00000000).
- misaligned is 0 in every cycle where branch_taken was not asserted on the prior edge.
- IF/ID update priority, highest first: reset > (flush or branch_taken) > stall > load.
  - flush=1 or branch_taken=1: bubble. if_id_valid <= 0, if_id_instr <= 0; if_id_pc and if_id_pc4 <= 0.
  - stall=1, no flush/branch: all IF/ID fields hold.
  - load: if_id_pc <= pc, if_id_pc4 <= pc+4 (same wrap rule), if_id_instr <= mem[pc], if_id_valid <= 1.
- Latency: an instruction at address A appears in IF/ID one cycle after pc=A, with no stall or flush in between.
- stall=1 and flush=1 together: IF/ID bubble, pc holds.
- Reset asserted mid-stream: the next edge applies reset values regardless of stall/flush/branch. The first valid IF/ID appears one cycle after reset deasserts and contains mem[RESET_PC].

Test Plan:
- Reset/load: hold reset 2 cycles while writing mem[0..3]=0x11,0x22,0x33,0x44 -> during reset pc=0, if_id_valid=0. After release: if_id_instr 0x11,0x22,0x33,0x44 on consecutive cycles, with if_id_pc 0,4,8,C and if_id_pc4 4,8,C,10.
- Stall: stall=1 for 2 cycles while pc=8 -> pc stays 8 and IF/ID holds {4,8,0x22,1}. After release, next IF/ID = {8,C,0x33,1}.
- Branch: branch_taken=1, branch_target=0x0000000E at pc=0xC -> next cycle pc=0xC, misaligned=1, if_id_valid=0. Following cycle if_id_instr=mem[3]=0x44, misaligned=0.
- Out of range: branch to 0x100 with MEM_DEPTH=64 -> if_id_instr=0, if_id_valid=1, if_id_pc=0x100.
- Wrap: branch to 0xFFFFFFFC -> if_id_pc4=0, and pc becomes 0x00000000 on the following cycle.
- Collisions: stall+flush together -> bubble, pc held. stall+branch together -> redirect wins, bubble inserted. Write to the word at the current pc -> old value fetched this cycle, new value on refetch.
